stoch_hyst_act_array: RTL

Parametrised, multi-channel stochastic-bitstream activation unit for the NN datapath. Each of N channels gates its input stream by a registered PASS/BLOCK mode. The mode switches with hysteresis on a sliding-window ones-count of the last DEPTH input bits, against runtime low/high thresholds. Blocked channels can optionally leak a scaled copy of the input through a shared leak stream. The block sits between neuron summation outputs and the next layer's inputs, and replaces fixed-memory single-channel activation cells.

---
 rtl/stoch_hyst_act_array.sv | 89 ++++++++
 1 files changed

// File: rtl/stoch_hyst_act_array.sv
// stoch_hyst_act_array
//
// Multi-channel stochastic-bitstream activation with hysteresis.
// Each channel has a sliding window over its last DEPTH input bits and a
// running ones-count. A registered PASS/BLOCK mode switches on that count
// against runtime thresholds:
//   PASS  -> BLOCK when the new count <= LO_TH
//   BLOCK -> PASS  when the new count >= HI_TH
// Only the transition that leaves the current mode is evaluated, so
// overlapping thresholds cannot conflict.
//
// The output is combinational: the current input bit is gated by the mode
// that earlier bits decided. A blocked channel outputs 0. With LEAK_EN set,
// it instead outputs z & LEAK, a scaled copy of the input.
//
// Parameters
//   N          number of independent channels
//   DEPTH      sliding-window length in bits (>= 2)
//   CW         count/threshold width; derived from DEPTH, do not override
//   INIT_STATE mode and window fill value loaded on reset
//   LEAK_EN    1: a blocked channel outputs z & LEAK; 0: it outputs 0
//
// Ports
//   CLK    clock; all state updates on the rising edge
//   INIT   synchronous active-high reset; has priority over EN
//   EN     stream-valid; 0 holds all state
//   z      input bitstreams, one bit per channel
//   LEAK   shared leak bitstream
//   LO_TH  PASS->BLOCK threshold (count <= LO_TH)
//   HI_TH  BLOCK->PASS threshold (count >= HI_TH)
//   a      activated bitstreams
//   mode   registered per-channel mode, 1 = PASS
module stoch_hyst_act_array #(
  parameter int       N          = 8,
  parameter int       DEPTH      = 4,
  parameter int       CW         = $clog2(DEPTH + 1),
  parameter logic     INIT_STATE = 1'b0,
  parameter logic     LEAK_EN    = 1'b0
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic          EN,
  input  logic [N-1:0]  z,
  input  logic          LEAK,
  input  logic [CW-1:0] LO_TH,
  input  logic [CW-1:0] HI_TH,
  output logic [N-1:0]  a,
  output logic [N-1:0]  mode
);

  localparam logic [CW-1:0] FILL_CNT = INIT_STATE ? CW'(DEPTH) : '0;

  // The result always lies in 0..DEPTH. Modulo-2^CW arithmetic is
  // therefore exact, even when cnt + z would briefly exceed CW bits.
  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt_cur,
                                               input logic          bit_in,
                                               input logic          bit_out);
    next_count = cnt_cur + CW'(bit_in) - CW'(bit_out);
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [DEPTH-1:0] win;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             mode_q;

    assign cnt_n = next_count(cnt, z[gi], win[DEPTH-1]);

    always_ff @(posedge CLK) begin
      if (INIT) begin
        win    <= {DEPTH{INIT_STATE}};
        cnt    <= FILL_CNT;
        mode_q <= INIT_STATE;
      end else if (EN) begin
        win <= {win[DEPTH-2:0], z[gi]};
        cnt <= cnt_n;
        if (mode_q && (cnt_n <= LO_TH)) begin
          mode_q <= 1'b0;
        end else if (!mode_q && (cnt_n >= HI_TH)) begin
          mode_q <= 1'b1;
        end
      end
    end

    assign mode[gi] = mode_q;
    assign a[gi]    = mode_q ? z[gi] : (LEAK_EN & z[gi] & LEAK);
  end

endmodule
